fft_peak_detect: RTL and testbench

//   Consumes the magnitude spectrum from the FFT/modulus stage (fft_data_valid,
//   fft_data) and finds, per FFT frame, the largest-magnitude bin and its index.

---
 rtl/fft_peak_if.sv | 22 ++
 rtl/fft_peak_detect.sv | 110 +++++++++++
 tb/tb_fft_peak_detect.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_if.sv
// Spectrum-to-peak-detector bus: magnitude stream in, per-frame peak report out.
interface fft_peak_if #(
    parameter int IDX_W = 10
);
    logic             fft_data_valid;
    logic [15:0]      fft_data;
    logic             peak_valid;
    logic [IDX_W-1:0] peak_bin;
    logic [15:0]      peak_mag;
    logic             frame_err;
    logic [15:0]      frame_cnt;

    modport master (
        output fft_data_valid, fft_data,
        input  peak_valid, peak_bin, peak_mag, frame_err, frame_cnt
    );

    modport slave (
        input  fft_data_valid, fft_data,
        output peak_valid, peak_bin, peak_mag, frame_err, frame_cnt
    );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame peak search over the FFT magnitude stream, with idle-timeout frame abort.
module fft_peak_detect #(
    parameter int FFT_LEN   = 1024,
    parameter int IDX_W     = 10,
    parameter int SKIP_BINS = 2,
    parameter int HALF_ONLY = 1,
    parameter int TIMEOUT   = 64
) (
    input logic         clk,
    input logic         rst_n,
    fft_peak_if.slave   bus
);
    localparam int HI_IDX = (HALF_ONLY != 0) ? (FFT_LEN / 2 - 1) : (FFT_LEN - 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LO_BIN   = IDX_W'(SKIP_BINS);
    localparam logic [IDX_W-1:0] HI_BIN   = IDX_W'(HI_IDX);
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FFT_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state;
    logic [IDX_W-1:0] bin_cnt;
    logic [IDX_W-1:0] best_bin;
    logic [15:0]      best_mag;
    logic [TO_W-1:0]  idle_cnt;
    logic [IDX_W-1:0] cur_bin;
    logic [IDX_W-1:0] nxt_bin;
    logic [15:0]      nxt_mag;

    logic             peak_valid_r;
    logic [IDX_W-1:0] peak_bin_r;
    logic [15:0]      peak_mag_r;
    logic             frame_err_r;
    logic [15:0]      frame_cnt_r;

    // A sample seen in IDLE is always bin 0, so back-to-back frames need no gap.
    always_comb begin
        cur_bin = (state == IDLE) ? '0 : bin_cnt;
        nxt_bin = best_bin;
        nxt_mag = best_mag;
        if (cur_bin == LO_BIN) begin
            nxt_bin = LO_BIN;
            nxt_mag = bus.fft_data;
        end else if ((cur_bin > LO_BIN) && (cur_bin <= HI_BIN) && (bus.fft_data > best_mag)) begin
            nxt_bin = cur_bin;
            nxt_mag = bus.fft_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bin_cnt      <= '0;
            best_bin     <= '0;
            best_mag     <= '0;
            idle_cnt     <= '0;
            peak_valid_r <= 1'b0;
            peak_bin_r   <= '0;
            peak_mag_r   <= '0;
            frame_err_r  <= 1'b0;
            frame_cnt_r  <= '0;
        end else begin
            peak_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (bus.fft_data_valid) begin
                        best_bin <= nxt_bin;
                        best_mag <= nxt_mag;
                        bin_cnt  <= IDX_W'(1);
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.fft_data_valid) begin
                        idle_cnt <= '0;
                        best_bin <= nxt_bin;
                        best_mag <= nxt_mag;
                        if (cur_bin == LAST_BIN) begin
                            peak_valid_r <= 1'b1;
                            peak_bin_r   <= nxt_bin;
                            peak_mag_r   <= nxt_mag;
                            frame_cnt_r  <= frame_cnt_r + 16'd1;
                            bin_cnt      <= '0;
                            state        <= IDLE;
                        end else begin
                            bin_cnt <= bin_cnt + IDX_W'(1);
                        end
                    end else if (idle_cnt == TO_LAST) begin
                        frame_err_r <= 1'b1;
                        idle_cnt    <= '0;
                        bin_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.peak_valid = peak_valid_r;
    assign bus.peak_bin   = peak_bin_r;
    assign bus.peak_mag   = peak_mag_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.frame_cnt  = frame_cnt_r;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Randomized self-checking bench: half-band and full-band detectors fed the same stream.
module tb_fft_peak_detect;
    localparam int FFT_LEN = 1024;
    localparam int IDX_W   = 10;
    localparam int SKIP    = 2;
    localparam int TIMEOUT = 64;
    localparam int HI_H    = FFT_LEN / 2 - 1;
    localparam int HI_F    = FFT_LEN - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0;
    logic [15:0] data = '0;
    logic [15:0] frame [FFT_LEN];
    int checks = 0;
    int errors = 0;
    int pv_h = 0;
    int fe_h = 0;
    int eb_h, em_h, eb_f, em_f;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    fft_peak_if #(.IDX_W(IDX_W)) bus_h ();
    fft_peak_if #(.IDX_W(IDX_W)) bus_f ();

    assign bus_h.fft_data_valid = valid;
    assign bus_h.fft_data       = data;
    assign bus_f.fft_data_valid = valid;
    assign bus_f.fft_data       = data;

    fft_peak_detect #(.FFT_LEN(FFT_LEN), .IDX_W(IDX_W), .SKIP_BINS(SKIP), .HALF_ONLY(1), .TIMEOUT(TIMEOUT))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus_h));
    fft_peak_detect #(.FFT_LEN(FFT_LEN), .IDX_W(IDX_W), .SKIP_BINS(SKIP), .HALF_ONLY(0), .TIMEOUT(TIMEOUT))
        dut_full (.clk(clk), .rst_n(rst_n), .bus(bus_f));

    always @(negedge clk) begin
        if (bus_h.peak_valid) pv_h++;
        if (bus_h.frame_err) fe_h++;
    end

    // Reference: largest magnitude in [SKIP, hi], then the first bin holding it.
    function automatic void model(input int hi, output int pbin, output int pmag);
        pmag = 0;
        for (int b = SKIP; b <= hi; b++) if (int'(frame[b]) > pmag) pmag = int'(frame[b]);
        pbin = SKIP;
        for (int b = hi; b >= SKIP; b--) if (int'(frame[b]) == pmag) pbin = b;
    endfunction

    // Sends bins 0..n-1; returns #1 after the edge accepting the last one, valid low.
    task automatic send_bins(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            data  = frame[i];
            @(posedge clk); #1;
            if (gap_max > 0 && i < n - 1) begin
                valid = 1'b0;
                data  = 16'($urandom);
                repeat ($urandom_range(1, gap_max)) @(posedge clk);
                #1;
            end
        end
        valid = 1'b0;
        data  = 16'($urandom);
    endtask

    task automatic fill_random();
        for (int i = 0; i < FFT_LEN; i++) frame[i] = 16'($urandom_range(0, 255));
    endtask

    task automatic check_frame(input string name);
        model(HI_H, eb_h, em_h);
        model(HI_F, eb_f, em_f);
        exp_cnt++;
        checks++;
        if (bus_h.peak_valid !== 1'b1) begin
            errors++; $display("FAIL %s peak_valid got %0b exp 1", name, bus_h.peak_valid);
        end
        checks++;
        if (int'(bus_h.peak_bin) !== eb_h || int'(bus_h.peak_mag) !== em_h) begin
            errors++; $display("FAIL %s half bin/mag got %0d/%0d exp %0d/%0d", name, bus_h.peak_bin, bus_h.peak_mag, eb_h, em_h);
        end
        checks++;
        if (int'(bus_f.peak_bin) !== eb_f || int'(bus_f.peak_mag) !== em_f) begin
            errors++; $display("FAIL %s full bin/mag got %0d/%0d exp %0d/%0d", name, bus_f.peak_bin, bus_f.peak_mag, eb_f, em_f);
        end
        checks++;
        if (int'(bus_h.frame_cnt) !== exp_cnt) begin
            errors++; $display("FAIL %s frame_cnt got %0d exp %0d", name, bus_h.frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_h.peak_valid, bus_h.peak_bin, bus_h.peak_mag, bus_h.frame_err, bus_h.frame_cnt} !== '0) begin
            errors++; $display("FAIL reset_outputs got v%0b b%0d m%0d e%0b c%0d exp 0", bus_h.peak_valid, bus_h.peak_bin, bus_h.peak_mag, bus_h.frame_err, bus_h.frame_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        int pv0;
        for (int i = 0; i < FFT_LEN; i++) frame[i] = 16'(i);
        pv0 = pv_h;
        send_bins(FFT_LEN, 0);
        checks++;
        if (pv_h !== pv0) begin
            errors++; $display("FAIL ramp_early_pulse got %0d pulses exp 0", pv_h - pv0);
        end
        check_frame("ramp");
        checks++;
        if (bus_h.peak_bin !== 10'd511 || bus_f.peak_bin !== 10'd1023) begin
            errors++; $display("FAIL ramp_bins got %0d/%0d exp 511/1023", bus_h.peak_bin, bus_f.peak_bin);
        end
        @(posedge clk); #1;
        checks++;
        if (bus_h.peak_valid !== 1'b0 || bus_h.peak_mag !== 16'd511) begin
            errors++; $display("FAIL ramp_hold got v%0b m%0d exp v0 m511", bus_h.peak_valid, bus_h.peak_mag);
        end
    endtask

    task automatic test_dc_tie();
        for (int i = 0; i < FFT_LEN; i++) frame[i] = 16'h0010;
        frame[0] = 16'hFFFF; frame[1] = 16'hF000; frame[100] = 16'h0800; frame[300] = 16'h0800;
        send_bins(FFT_LEN, 0);
        check_frame("dc_tie");
        checks++;
        if (bus_h.peak_bin !== 10'd100 || bus_h.peak_mag !== 16'h0800) begin
            errors++; $display("FAIL dc_tie_fixed got %0d/%0h exp 100/0800", bus_h.peak_bin, bus_h.peak_mag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_half_band();
        for (int i = 0; i < FFT_LEN; i++) frame[i] = '0;
        frame[700] = 16'hFFFF; frame[5] = 16'h0100;
        send_bins(FFT_LEN, 0);
        check_frame("half_band");
        checks++;
        if (bus_h.peak_bin !== 10'd5 || bus_f.peak_bin !== 10'd700) begin
            errors++; $display("FAIL half_band_fixed got %0d/%0d exp 5/700", bus_h.peak_bin, bus_f.peak_bin);
        end
        for (int i = 0; i < FFT_LEN; i++) frame[i] = '0;
        send_bins(FFT_LEN, 0);
        check_frame("all_zero");
        checks++;
        if (bus_h.peak_bin !== 10'(SKIP) || bus_h.peak_mag !== 16'd0) begin
            errors++; $display("FAIL all_zero_fixed got %0d/%0d exp %0d/0", bus_h.peak_bin, bus_h.peak_mag, SKIP);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int pv0, fe0, k, seen;
        logic [15:0] mag0;
        pv0 = pv_h; fe0 = fe_h; mag0 = bus_h.peak_mag; seen = 0;
        fill_random();
        send_bins(300, 0);
        for (k = 1; k <= 3 * TIMEOUT; k++) begin
            @(posedge clk); #1;
            if (bus_h.frame_err) begin seen = k; break; end
        end
        checks++;
        if (seen !== TIMEOUT) begin
            errors++; $display("FAIL timeout_latency got %0d exp %0d", seen, TIMEOUT);
        end
        checks++;
        if (pv_h !== pv0 || int'(bus_h.frame_cnt) !== exp_cnt || bus_h.peak_mag !== mag0) begin
            errors++; $display("FAIL timeout_no_report got pulses %0d cnt %0d exp 0 %0d", pv_h - pv0, bus_h.frame_cnt, exp_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (fe_h - fe0 !== 1) begin
            errors++; $display("FAIL timeout_pulse got %0d pulses exp 1", fe_h - fe0);
        end
        fill_random();
        send_bins(FFT_LEN, 0);
        check_frame("after_timeout");
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int pv0;
        pv0 = pv_h;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            if (f == 1) frame[HI_H] = 16'd300;
            send_bins(FFT_LEN, 10);
            check_frame("back_to_back");
        end
        @(posedge clk); #1;
        checks++;
        if (pv_h - pv0 !== 3) begin
            errors++; $display("FAIL b2b_pulses got %0d exp 3", pv_h - pv0);
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        send_bins(400, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_h.peak_bin, bus_h.peak_mag, bus_h.frame_cnt} !== '0) begin
            errors++; $display("FAIL async_reset got b%0d m%0d c%0d exp 0", bus_h.peak_bin, bus_h.peak_mag, bus_h.frame_cnt);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk); #1;
        fill_random();
        send_bins(FFT_LEN, 3);
        check_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_dc_tie();
        test_half_band();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
